// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: datapath words, cache lines and the
// cache arbiter's state and side-select encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_8words;
  typedef logic [11:0]  lc3b_line_addr;
  typedef logic [15:0]  lc3b_line_sel;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state_t;

  typedef logic arb_side_t;
  localparam arb_side_t ARB_I = 1'b0;
  localparam arb_side_t ARB_D = 1'b1;

  localparam lc3b_line_sel SEL_ALL = 16'hFFFF;

endpackage

// File: rtl/wishbone.sv
// Line-granular wishbone bundle used between the L1 caches, the arbiter
// and the downstream memory port.
interface wishbone (
  input logic CLK
);
  import lc3b_types::*;

  lc3b_line_addr ADR;
  lc3b_8words    DAT_M;
  lc3b_8words    DAT_S;
  lc3b_line_sel  SEL;
  logic          WE;
  logic          CYC;
  logic          STB;
  logic          ACK;
  logic          RTY;

  modport master (
    input  CLK, DAT_S, ACK, RTY,
    output ADR, DAT_M, SEL, WE, CYC, STB
  );

  modport slave (
    input  CLK, ADR, DAT_M, SEL, WE, CYC, STB,
    output DAT_S, ACK, RTY
  );

endinterface

// File: rtl/cache_arbiter_control.sv
// Arbiter control: grant FSM, round-robin priority bit and the
// transaction / conflict performance counters.
module cache_arbiter_control
  import lc3b_types::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             cyc_d,
  input  logic             stb_d,
  input  logic             mem_ack,
  output logic             grant_valid,
  output arb_side_t        grant_sel,
  output logic [CNT_W-1:0] icache_grant_count,
  output logic [CNT_W-1:0] dcache_grant_count,
  output logic [CNT_W-1:0] conflict_count
);

  arb_state_t state;
  arb_side_t  prio;
  logic       req_i;
  logic       req_d;
  logic       win_valid;
  arb_side_t  win_sel;

  always_comb begin
    req_i     = cyc_i & stb_i;
    req_d     = cyc_d & stb_d;
    win_valid = req_i | req_d;
    win_sel   = ARB_D;
    if (req_i && req_d) begin
      win_sel = prio;
    end else if (req_i) begin
      win_sel = ARB_I;
    end
  end

  // grant_valid/grant_sel are registered alongside state so the steering
  // muxes in the top level never see a combinational path from the requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      prio               <= ARB_D;
      grant_valid        <= 1'b0;
      grant_sel          <= ARB_D;
      icache_grant_count <= '0;
      dcache_grant_count <= '0;
      conflict_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_i && req_d) begin
            conflict_count <= conflict_count + CNT_W'(1);
            prio           <= (prio == ARB_I) ? ARB_D : ARB_I;
          end
          if (win_valid) begin
            state       <= (win_sel == ARB_I) ? GNT_I : GNT_D;
            grant_valid <= 1'b1;
            grant_sel   <= win_sel;
          end
        end
        GNT_I: begin
          if (!cyc_i) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end else if (mem_ack) begin
            icache_grant_count <= icache_grant_count + CNT_W'(1);
            prio               <= ARB_D;
            state              <= IDLE;
            grant_valid        <= 1'b0;
          end
        end
        GNT_D: begin
          if (!cyc_d) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end else if (mem_ack) begin
            dcache_grant_count <= dcache_grant_count + CNT_W'(1);
            prio               <= ARB_I;
            state              <= IDLE;
            grant_valid        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one downstream wishbone line port between the L1 I-cache and
// D-cache; this level only steers buses according to the control's grant.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  wishbone.slave           wb_icache,
  wishbone.slave           wb_dcache,
  wishbone.master          wb_mem,
  output logic [CNT_W-1:0] icache_grant_count,
  output logic [CNT_W-1:0] dcache_grant_count,
  output logic [CNT_W-1:0] conflict_count
);

  logic      grant_valid;
  arb_side_t grant_sel;
  logic      gnt_i;
  logic      gnt_d;

  cache_arbiter_control #(
    .CNT_W(CNT_W)
  ) u_control (
    .clk                (clk),
    .rst_n              (rst_n),
    .cyc_i              (wb_icache.CYC),
    .stb_i              (wb_icache.STB),
    .cyc_d              (wb_dcache.CYC),
    .stb_d              (wb_dcache.STB),
    .mem_ack            (wb_mem.ACK),
    .grant_valid        (grant_valid),
    .grant_sel          (grant_sel),
    .icache_grant_count (icache_grant_count),
    .dcache_grant_count (dcache_grant_count),
    .conflict_count     (conflict_count)
  );

  always_comb begin
    gnt_i = grant_valid && (grant_sel == ARB_I);
    gnt_d = grant_valid && (grant_sel == ARB_D);
  end

  always_comb begin
    wb_mem.CYC   = grant_valid;
    wb_mem.STB   = grant_valid;
    wb_mem.ADR   = '0;
    wb_mem.DAT_M = '0;
    wb_mem.SEL   = SEL_ALL;
    wb_mem.WE    = 1'b0;
    if (gnt_i) begin
      wb_mem.ADR   = wb_icache.ADR;
      wb_mem.DAT_M = wb_icache.DAT_M;
      wb_mem.SEL   = wb_icache.SEL;
      wb_mem.WE    = wb_icache.WE;
    end else if (gnt_d) begin
      wb_mem.ADR   = wb_dcache.ADR;
      wb_mem.DAT_M = wb_dcache.DAT_M;
      wb_mem.SEL   = wb_dcache.SEL;
      wb_mem.WE    = wb_dcache.WE;
    end
  end

  // A waiting side is told to retry for as long as it keeps requesting.
  always_comb begin
    wb_icache.DAT_S = wb_mem.DAT_S;
    wb_icache.ACK   = gnt_i & wb_mem.ACK;
    wb_icache.RTY   = gnt_i ? wb_mem.RTY : (wb_icache.CYC & wb_icache.STB);
    wb_dcache.DAT_S = wb_mem.DAT_S;
    wb_dcache.ACK   = gnt_d & wb_mem.ACK;
    wb_dcache.RTY   = gnt_d ? wb_mem.RTY : (wb_dcache.CYC & wb_dcache.STB);
  end

endmodule
